// File: rtl/sprite_pkg.sv
// Shared constants and FSM encoding for the sprite line fetch stage.
package sprite_pkg;
   localparam int SPRITE_DIM    = 16;
   localparam int PIX_BITS      = 4;
   localparam int WORDS_PER_ROW = 4;
   localparam int FRAME_WORDS   = 64;
   localparam logic [PIX_BITS-1:0] TRANSPARENT_IDX = '0;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_DRAIN
   } fetch_state_e;
endpackage

// File: rtl/sprite_pixel_sel.sv
// Combinational column range check and word/nibble select from the row buffer.
// Slot w occupies row_buf_i[w*16 +: 16]; nibble 0 of a word is its MSBs (leftmost pixel).
module sprite_pixel_sel
   import sprite_pkg::*;
#(
   parameter int DIM = sprite_pkg::SPRITE_DIM
) (
   input  logic [63:0]         row_buf_i,
   input  logic                row_valid_i,
   input  logic [9:0]          hcount_i,
   input  logic [9:0]          sprite_x_i,
   output logic [PIX_BITS-1:0] idx_o,
   output logic                vld_o
);

   logic [10:0]         col;
   logic                in_range;
   logic [15:0]         word;
   logic [PIX_BITS-1:0] nib;

   always_comb begin
      // Columns left of the sprite wrap to >= 2048-1023, so one unsigned compare covers both edges.
      col      = {1'b0, hcount_i} - {1'b0, sprite_x_i};
      in_range = row_valid_i && (col < 11'(DIM));
      word     = row_buf_i[{col[3:2], 4'b0000} +: 16];
      nib      = word[{~col[1:0], 2'b00} +: PIX_BITS];
      idx_o    = in_range ? nib : TRANSPARENT_IDX;
      vld_o    = in_range && (nib != TRANSPARENT_IDX);
   end

endmodule

// File: rtl/sprite_line_fetch.sv
// Per-line sprite row fetch (4 ROM words into a row buffer) and registered pixel select.
// Fetch: line_start at edge T -> issue T+1..T+4, capture T+2..T+5, row_valid from T+6.
module sprite_line_fetch
   import sprite_pkg::*;
#(
   parameter int FRAME_WORDS = sprite_pkg::FRAME_WORDS,
   parameter int SPRITE_DIM  = sprite_pkg::SPRITE_DIM
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        line_start,
   input  logic [9:0]  line_y,
   input  logic [9:0]  hcount,
   input  logic [9:0]  sprite_x,
   input  logic [9:0]  sprite_y,
   input  logic        frame,
   input  logic        enable,
   output logic [6:0]  rom_address,
   output logic        rom_chipselect,
   output logic        rom_clken,
   input  logic [15:0] rom_readdata,
   output logic        busy,
   output logic        row_valid,
   output logic        pixel_valid,
   output logic [3:0]  pixel_index
);

   fetch_state_e state_q, state_d;
   logic [1:0]   w_q, w_d;
   logic [3:0]   dy_q, dy_d;
   logic         frame_q, frame_d;
   logic [9:0]   sx_q, sx_d;
   logic         row_valid_q, row_valid_d;
   logic         cap_vld_q, cap_vld_d;
   logic [1:0]   cap_slot_q, cap_slot_d;
   logic [63:0]  row_buf_q, row_buf_d;
   logic [3:0]   pix_idx_q;
   logic         pix_vld_q;
   logic [3:0]   sel_idx;
   logic         sel_vld;
   logic [10:0]  dy_full;
   logic         hit;

   always_comb begin
      state_d     = state_q;
      w_d         = w_q;
      dy_d        = dy_q;
      frame_d     = frame_q;
      sx_d        = sx_q;
      row_valid_d = row_valid_q;
      row_buf_d   = row_buf_q;
      cap_vld_d   = (state_q == ST_ISSUE);
      cap_slot_d  = w_q;

      dy_full = {1'b0, line_y} - {1'b0, sprite_y};
      hit     = enable && (line_y >= sprite_y) && (dy_full < 11'(SPRITE_DIM));

      if (line_start) begin
         // Restart: the read already returning belongs to the old row and is dropped.
         sx_d        = sprite_x;
         frame_d     = frame;
         row_valid_d = 1'b0;
         cap_vld_d   = 1'b0;
         w_d         = 2'd0;
         dy_d        = dy_full[3:0];
         state_d     = hit ? ST_ISSUE : ST_IDLE;
      end else begin
         if (cap_vld_q) begin
            row_buf_d[{cap_slot_q, 4'b0000} +: 16] = rom_readdata;
         end
         case (state_q)
            ST_ISSUE: begin
               if (w_q == 2'(WORDS_PER_ROW - 1)) begin
                  state_d = ST_DRAIN;
               end else begin
                  w_d = w_q + 2'd1;
               end
            end
            ST_DRAIN: begin
               state_d     = ST_IDLE;
               row_valid_d = 1'b1;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         w_q         <= '0;
         dy_q        <= '0;
         frame_q     <= 1'b0;
         sx_q        <= '0;
         row_valid_q <= 1'b0;
         cap_vld_q   <= 1'b0;
         cap_slot_q  <= '0;
         row_buf_q   <= '0;
         pix_idx_q   <= '0;
         pix_vld_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         w_q         <= w_d;
         dy_q        <= dy_d;
         frame_q     <= frame_d;
         sx_q        <= sx_d;
         row_valid_q <= row_valid_d;
         cap_vld_q   <= cap_vld_d;
         cap_slot_q  <= cap_slot_d;
         row_buf_q   <= row_buf_d;
         pix_idx_q   <= sel_idx;
         pix_vld_q   <= sel_vld;
      end
   end

   sprite_pixel_sel #(
      .DIM(SPRITE_DIM)
   ) u_sel (
      .row_buf_i  (row_buf_q),
      .row_valid_i(row_valid_q),
      .hcount_i   (hcount),
      .sprite_x_i (sx_q),
      .idx_o      (sel_idx),
      .vld_o      (sel_vld)
   );

   assign rom_chipselect = (state_q == ST_ISSUE);
   assign rom_address    = rom_chipselect
                         ? (frame_q ? 7'(FRAME_WORDS) : 7'd0) + {1'b0, dy_q, w_q}
                         : 7'd0;
   assign rom_clken      = 1'b1;
   assign busy           = (state_q != ST_IDLE);
   assign row_valid      = row_valid_q;
   assign pixel_valid    = pix_vld_q;
   assign pixel_index    = pix_idx_q;

endmodule

// File: tb/tb_sprite_line_fetch.sv
// Directed bench for sprite_line_fetch with a registered ROM model.
module tb_sprite_line_fetch;

   logic        clk = 1'b0;
   logic        reset;
   logic        line_start;
   logic [9:0]  line_y;
   logic [9:0]  hcount;
   logic [9:0]  sprite_x;
   logic [9:0]  sprite_y;
   logic        frame;
   logic        enable;
   logic [6:0]  rom_address;
   logic        rom_chipselect;
   logic        rom_clken;
   logic [15:0] rom_readdata = 16'h0;
   logic        busy;
   logic        row_valid;
   logic        pixel_valid;
   logic [3:0]  pixel_index;

   logic [15:0] mem [128];
   int          checks   = 0;
   int          failures = 0;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (rom_clken && rom_chipselect) rom_readdata <= mem[rom_address];
   end

   sprite_line_fetch dut (
      .clk           (clk),
      .reset         (reset),
      .line_start    (line_start),
      .line_y        (line_y),
      .hcount        (hcount),
      .sprite_x      (sprite_x),
      .sprite_y      (sprite_y),
      .frame         (frame),
      .enable        (enable),
      .rom_address   (rom_address),
      .rom_chipselect(rom_chipselect),
      .rom_clken     (rom_clken),
      .rom_readdata  (rom_readdata),
      .busy          (busy),
      .row_valid     (row_valid),
      .pixel_valid   (pixel_valid),
      .pixel_index   (pixel_index)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Drives a line_start pulse; returns #1 into cycle T+1.
   task automatic pulse(input int ly, input int sy, input int sx, input bit fr, input bit en);
      line_y     = 10'(ly);
      sprite_y   = 10'(sy);
      sprite_x   = 10'(sx);
      frame      = fr;
      enable     = en;
      line_start = 1'b1;
      step();
      line_start = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step();
      step();
      checks++;
      if ({busy, rom_chipselect, rom_address, row_valid, pixel_valid, pixel_index} !== 15'd0) begin
         failures++;
         $display("FAIL reset_outputs: got busy=%b cs=%b addr=%h rv=%b pv=%b idx=%h required all 0",
                  busy, rom_chipselect, rom_address, row_valid, pixel_valid, pixel_index);
      end
      checks++;
      if (rom_clken !== 1'b1) begin
         failures++;
         $display("FAIL reset_clken: got %b required 1", rom_clken);
      end
      reset = 1'b0;
      step();

      // Reset asserted mid-fetch, sampled at edge T+3.
      pulse(103, 100, 0, 1'b1, 1'b1);
      step();
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      checks++;
      if ({busy, rom_chipselect, rom_address, row_valid, pixel_valid, pixel_index} !== 15'd0) begin
         failures++;
         $display("FAIL reset_midfetch: got busy=%b cs=%b addr=%h rv=%b pv=%b idx=%h required all 0",
                  busy, rom_chipselect, rom_address, row_valid, pixel_valid, pixel_index);
      end

      begin
         bit seen;
         seen = 1'b0;
         pulse(50, 100, 0, 1'b1, 1'b1);
         for (int i = 0; i < 7; i++) begin
            if (rom_chipselect || busy) seen = 1'b1;
            step();
         end
         checks++;
         if (seen !== 1'b0 || row_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_then_miss: got rom_access=%b row_valid=%b required 0 0", seen, row_valid);
         end
      end
   endtask

   task automatic test_hit_fetch();
      pulse(103, 100, 0, 1'b1, 1'b1);
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (rom_address !== 7'(8'h4C + k) || rom_chipselect !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL hit_issue_%0d: got addr=%h cs=%b busy=%b required addr=%h cs=1 busy=1",
                     k, rom_address, rom_chipselect, busy, 8'h4C + k);
         end
         step();
      end
      checks++;
      if (busy !== 1'b1 || rom_chipselect !== 1'b0 || row_valid !== 1'b0) begin
         failures++;
         $display("FAIL hit_drain: got busy=%b cs=%b rv=%b required 1 0 0", busy, rom_chipselect, row_valid);
      end
      step();
      checks++;
      if (row_valid !== 1'b1 || busy !== 1'b0) begin
         failures++;
         $display("FAIL hit_row_valid: got rv=%b busy=%b required 1 0", row_valid, busy);
      end
   endtask

   task automatic test_pixels();
      int hc [8]  = '{200, 201, 203, 211, 212, 199, 216, 215};
      int ei [8]  = '{1,   2,   0,   15,  10,  0,   0,   0};
      bit ev [8]  = '{1,   1,   0,   1,   1,   0,   0,   0};
      pulse(105, 100, 200, 1'b0, 1'b1);
      for (int i = 0; i < 5; i++) step();
      for (int i = 0; i < 8; i++) begin
         hcount = 10'(hc[i]);
         step();
         checks++;
         if (pixel_index !== 4'(ei[i]) || pixel_valid !== ev[i]) begin
            failures++;
            $display("FAIL pixel_h%0d: got idx=%0d valid=%b required idx=%0d valid=%b",
                     hc[i], pixel_index, pixel_valid, ei[i], ev[i]);
         end
      end
   endtask

   task automatic test_miss();
      int ly [3] = '{116, 3,    103};
      int sy [3] = '{100, 1020, 100};
      bit en [3] = '{1,   1,    0};
      for (int s = 0; s < 3; s++) begin
         bit seen;
         seen = 1'b0;
         pulse(ly[s], sy[s], 0, 1'b1, en[s]);
         for (int i = 0; i < 7; i++) begin
            if (rom_chipselect || busy) seen = 1'b1;
            step();
         end
         checks++;
         if (seen !== 1'b0 || row_valid !== 1'b0) begin
            failures++;
            $display("FAIL miss_%0d: got rom_access=%b row_valid=%b required 0 0", s, seen, row_valid);
         end
      end
   endtask

   task automatic test_restart();
      int hc [5] = '{0, 3, 4, 8, 12};
      int ei [5] = '{1, 1, 2, 3, 4};
      pulse(103, 100, 0, 1'b1, 1'b1);
      checks++;
      if (rom_address !== 7'h4C) begin
         failures++;
         $display("FAIL restart_first_addr: got %h required 4c", rom_address);
      end
      step();
      pulse(104, 100, 0, 1'b1, 1'b1);
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (rom_address !== 7'(8'h50 + k) || rom_chipselect !== 1'b1) begin
            failures++;
            $display("FAIL restart_issue_%0d: got addr=%h cs=%b required addr=%h cs=1",
                     k, rom_address, rom_chipselect, 8'h50 + k);
         end
         step();
      end
      checks++;
      if (row_valid !== 1'b0 || busy !== 1'b1) begin
         failures++;
         $display("FAIL restart_t5: got rv=%b busy=%b required 0 1", row_valid, busy);
      end
      step();
      checks++;
      if (row_valid !== 1'b1) begin
         failures++;
         $display("FAIL restart_row_valid: got %b required 1", row_valid);
      end
      for (int i = 0; i < 5; i++) begin
         hcount = 10'(hc[i]);
         step();
         checks++;
         if (pixel_index !== 4'(ei[i]) || pixel_valid !== 1'b1) begin
            failures++;
            $display("FAIL restart_pixel_h%0d: got idx=%0d valid=%b required idx=%0d valid=1",
                     hc[i], pixel_index, pixel_valid, ei[i]);
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 128; i++) mem[i] = 16'h0000;
      mem[20] = 16'h1230;  mem[21] = 16'h0000;  mem[22] = 16'h000F;  mem[23] = 16'hA000;
      mem[7'h4C] = 16'h9999;  mem[7'h4D] = 16'hAAAA;  mem[7'h4E] = 16'hBBBB;  mem[7'h4F] = 16'hCCCC;
      mem[7'h50] = 16'h1111;  mem[7'h51] = 16'h2222;  mem[7'h52] = 16'h3333;  mem[7'h53] = 16'h4444;

      reset      = 1'b1;
      line_start = 1'b0;
      line_y     = '0;
      hcount     = '0;
      sprite_x   = '0;
      sprite_y   = '0;
      frame      = 1'b0;
      enable     = 1'b0;

      test_reset();
      test_hit_fetch();
      test_pixels();
      test_miss();
      test_restart();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/sprite_line_fetch.md
# sprite_line_fetch

Per-scanline sprite fetch and pixel-select stage that sits directly downstream of a 128×16 sprite ROM (two 16×16 frames, 4 bpp). On each line-start pulse from the VGA timing logic it decides whether the next scanline crosses the sprite and, if so, reads that sprite row (four 16-bit words) from the ROM into a row buffer. During the active line it returns the palette index of the sprite pixel under the current `hcount`. Its output feeds the layer compositor.

## Interface
Parameters:
- `FRAME_WORDS`, 64: ROM words per animation frame (16 rows × 4 words).
- `SPRITE_DIM`, 16: sprite width and height in pixels.

Ports:
- `clk`  in  1  single clock for the block and the ROM.
- `reset`  in  1  synchronous, active-high.
- `line_start`  in  1  one-cycle pulse at the start of hblank.
- `line_y`  in  10  scanline about to be displayed; sampled with `line_start`.
- `hcount`  in  10  current pixel column.
- `sprite_x`, `sprite_y`  in  10 each  top-left sprite position; sampled with `line_start`.
- `frame`  in  1  animation frame select; sampled with `line_start`.
- `enable`  in  1  sprite shown; sampled with `line_start`.
- `rom_address`  out  7  ROM word address.
- `rom_chipselect`  out  1  high only on fetch-issue cycles.
- `rom_clken`  out  1  constant 1 after reset.
- `rom_readdata`  in  16  ROM data, valid one cycle after the address is presented.
- `busy`  out  1  a fetch is in progress.
- `row_valid`  out  1  the row buffer holds the row for the current line.
- `pixel_valid`  out  1  an opaque sprite pixel is at the previous cycle's `hcount`.
- `pixel_index`  out  4  palette index for that pixel.

## Operation
- Reset: all outputs 0 except `rom_clken`. Row buffer cleared. State is IDLE.
- FSM has three states: IDLE, ISSUE (4 cycles, word counter w = 0..3), and DRAIN (1 cycle, last capture). DRAIN returns to IDLE.
- On `line_start`, `sprite_x`, `frame` and `enable` are latched and `row_valid` is cleared.
  - Hit test is computed in 11-bit arithmetic with no wrap: hit = `enable` and `line_y` ≥ `sprite_y` and (`line_y` − `sprite_y`) < 16.
  - On a hit, the FSM enters ISSUE with dy = (`line_y` − `sprite_y`)[3:0]. On a miss, the FSM stays in or returns to IDLE.
- Address for word w is `{frame, dy, w}`, i.e. frame·64 + dy·4 + w. Word w is captured into buffer slot w.
- Pixel select:
  - col = `hcount` − latched `sprite_x`, computed in 11 bits. The pixel is in range iff `row_valid` and 0 ≤ col < 16.
  - Word = col[3:2]. Nibble = col[1:0], with nibble 0 being bits [15:12] (leftmost pixel in the MSBs).
  - `pixel_index` is that nibble when in range, else 0. `pixel_valid` = in range and index ≠ 0 (index 0 is transparent).
- A `line_start` during ISSUE or DRAIN aborts the current fetch and restarts it from the new sampled values. Data still in flight from the aborted fetch is discarded.
- `reset` mid-fetch returns the block to the reset state on the next edge.

## Timing
- `line_start` is sampled at edge T.
  - `rom_address` = base+0..3 with `rom_chipselect` = 1 during cycles T+1..T+4.
  - `rom_readdata` is captured at the ends of cycles T+2..T+5.
  - `busy` = 1 during T+1..T+5. `row_valid` = 1 from T+6.
- Total fetch time is 6 cycles, which is well inside the 160-cycle hblank.
- Pixel path: `pixel_index` and `pixel_valid` are registered, so the output for `hcount` h appears one cycle after h is presented.
- On a miss, `busy` and `rom_chipselect` stay 0 and `row_valid` stays 0 until the next hit.

## Structure
- Shared package `sprite_pkg`: `SPRITE_DIM`, `PIX_BITS`=4, `WORDS_PER_ROW`=4, `FRAME_WORDS`, the FSM state enum, and the transparent index 0.
- One sub-module, `sprite_pixel_sel`: the combinational column range check plus the word/nibble mux from the row buffer. The FSM, fetch counter and buffer stay in the top module.

## Test plan
- Reset mid-fetch (assert `reset` at T+3) → all outputs 0 on the next edge; a `line_start` with no hit afterwards → no ROM access.
- Hit fetch: `sprite_y`=100, `line_y`=103, `frame`=1 → `rom_address` 0x4C, 0x4D, 0x4E, 0x4F on T+1..T+4; `busy` high T+1..T+5; `row_valid` high at T+6.
- Pixel output: row words 0x1230, 0x0000, 0x000F, 0xA000 and `sprite_x`=200.
  - `hcount` 200 → index 1 valid; 203 → index 0 and not valid; 211 → index 15 valid; 212 → index 10 valid.
  - 199 and 216 → `pixel_valid` 0.
- Vertical miss and no-wrap: (`sprite_y`=100, `line_y`=116) and (`sprite_y`=1020, `line_y`=3) → no `rom_chipselect` and `row_valid` 0. Setting `enable`=0 on a geometric hit → no fetch.
- Restart: a second `line_start` at T+2 with `line_y`=104 → the address sequence restarts at 0x50 (frame 1, dy 4) and `row_valid` rises 6 cycles after the second pulse, with buffer contents from the new row only.
